// File: rtl/dpu_quant_pkg.sv
// Shared widths, INT8 limits and per-stage payload types for the quantisation pipelines.
package dpu_quant_pkg;

  localparam int unsigned IN_W    = 32;
  localparam int unsigned SCALE_W = 16;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned PROD_W  = IN_W + SCALE_W + 1;
  localparam int unsigned SUM_W   = PROD_W + 1;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef struct packed {
    logic signed [PROD_W-1:0]  p;
    logic        [SHIFT_W-1:0] shift;
    logic signed [OUT_W-1:0]   zp;
  } s1_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] r;
    logic signed [OUT_W-1:0]  zp;
  } s2_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] y;
    logic                    sat;
  } s3_t;

endpackage

// File: rtl/requant_int8_if.sv
// Valid/ready stream bundle for the INT8 requantiser: activation + per-beat config in, INT8 out.
interface requant_int8_if;
  import dpu_quant_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [IN_W-1:0]    x;
  logic        [SCALE_W-1:0] scale;
  logic        [SHIFT_W-1:0] shift;
  logic signed [OUT_W-1:0]   zero_point;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   y;
  logic                      sat;

  modport master (
    output in_valid, x, scale, shift, zero_point, out_ready,
    input  in_ready, out_valid, y, sat
  );

  modport slave (
    input  in_valid, x, scale, shift, zero_point, out_ready,
    output in_ready, out_valid, y, sat
  );

endinterface

// File: rtl/sat_int8.sv
// Saturates a wide signed value to INT8 and flags when clipping happened.
module sat_int8
  import dpu_quant_pkg::*;
#(
  parameter int unsigned W = SUM_W
) (
  input  logic signed [W-1:0]     d,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat
);

  localparam logic signed [W-1:0] MAX_V = W'(INT8_MAX);
  localparam logic signed [W-1:0] MIN_V = W'(INT8_MIN);

  always_comb begin
    q   = d[OUT_W-1:0];
    sat = 1'b0;
    if (d > MAX_V) begin
      q   = OUT_W'(INT8_MAX);
      sat = 1'b1;
    end else if (d < MIN_V) begin
      q   = OUT_W'(INT8_MIN);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/requant_int8.sv
// Three-stage requantiser: multiply, round+shift, offset+saturate; whole pipe stalls together.
module requant_int8
  import dpu_quant_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  requant_int8_if.slave  bus
);

  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic v3_q, v3_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;
  logic en;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] scale_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  round_sum;
  logic signed [PROD_W-1:0] r_next;
  logic signed [SUM_W-1:0]  sum3;
  logic signed [OUT_W-1:0]  y_sat;
  logic                     sat_flag;

  // Stage arithmetic; the rounding sum gets one guard bit so it never wraps.
  always_comb begin
    x_ext     = PROD_W'(bus.x);
    scale_ext = $signed(PROD_W'(bus.scale));
    prod      = x_ext * scale_ext;
    round_sum = SUM_W'(s1_q.p) + (SUM_W'(1) << (s1_q.shift - SHIFT_W'(1)));
    r_next    = (s1_q.shift == '0) ? s1_q.p : PROD_W'(round_sum >>> s1_q.shift);
    sum3      = SUM_W'(s2_q.r) + SUM_W'(s2_q.zp);
  end

  sat_int8 #(.W(SUM_W)) u_sat (
    .d   (sum3),
    .q   (y_sat),
    .sat (sat_flag)
  );

  // Single enable: an unconsumed output freezes every stage.
  always_comb begin
    en   = !v3_q || bus.out_ready;
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (en) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (bus.in_valid) s1_d = '{p: prod, shift: bus.shift, zp: bus.zero_point};
      if (v1_q)         s2_d = '{r: r_next, zp: s1_q.zp};
      if (v2_q)         s3_d = '{y: y_sat, sat: sat_flag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v3_q;
  assign bus.y         = s3_q.y;
  assign bus.sat       = s3_q.sat;

endmodule

// File: tb/tb_requant_int8.sv
// Bench for requant_int8: directed beats with literal results, then randomized traffic with backpressure.
module tb_requant_int8;
  import dpu_quant_pkg::*;

  typedef struct {
    int          x;
    int unsigned scale;
    int          shift;
    int          zp;
    bit          has_lit;
    int          lit_y;
    bit          lit_sat;
    int          acc_cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  requant_int8_if bus();

  requant_int8 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ready_run = 0;
  bit    prev_hold = 0;
  int    prev_y;
  int    prev_sat;
  bit    drv_fire;
  beat_t cur;
  beat_t stim_q[$];
  beat_t exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, floor after adding half an LSB, then clamp to INT8.
  function automatic void model(input beat_t b, output int y, output bit s);
    longint p, r, v;
    p = longint'(b.x) * longint'(b.scale);
    if (b.shift == 0) r = p;
    else              r = (p + (longint'(1) <<< (b.shift - 1))) >>> b.shift;
    v = r + longint'(b.zp);
    s = 1'b0;
    if (v > 127)       begin v = 127;  s = 1'b1; end
    else if (v < -128) begin v = -128; s = 1'b1; end
    y = int'(v);
  endfunction

  task automatic push(input int x, input int unsigned sc, input int sh, input int zp,
                      input bit lit, input int ly, input bit ls);
    beat_t b;
    b.x = x; b.scale = sc; b.shift = sh; b.zp = zp;
    b.has_lit = lit; b.lit_y = ly; b.lit_sat = ls; b.acc_cyc = 0;
    stim_q.push_back(b);
  endtask

  task automatic push_rand();
    beat_t b;
    case ($urandom_range(0, 3))
      0:       b.x = int'($urandom_range(0, 400)) - 200;
      1:       b.x = int'($urandom);
      2:       b.x = int'($urandom_range(0, 100000)) - 50000;
      default: b.x = int'($urandom_range(0, 3000)) - 1500;
    endcase
    b.scale = $urandom_range(0, 65535);
    b.shift = int'($urandom_range(0, 31));
    b.zp    = int'($urandom_range(0, 255)) - 128;
    b.has_lit = 1'b0; b.lit_y = 0; b.lit_sat = 1'b0; b.acc_cyc = 0;
    stim_q.push_back(b);
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0 || bus.in_valid) && n < budget) begin
      @(posedge clk); #2;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
      n++;
    end
    bus.out_ready = 1'b1;
    check("drain_done", longint'(n < budget), 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver: presents queued beats, holding each until it is accepted.
  initial begin
    bus.in_valid = 1'b0; bus.x = '0; bus.scale = '0; bus.shift = '0; bus.zero_point = '0;
    forever begin
      @(negedge clk);
      drv_fire = bus.in_valid && bus.in_ready && !rst;
      @(posedge clk); #1;
      if (rst) begin
        bus.in_valid = 1'b0;
      end else if (drv_fire || !bus.in_valid) begin
        if (stim_q.size() != 0) begin
          cur = stim_q.pop_front();
          bus.x          = cur.x;
          bus.scale      = SCALE_W'(cur.scale);
          bus.shift      = SHIFT_W'(cur.shift);
          bus.zero_point = OUT_W'(cur.zp);
          bus.in_valid   = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
  end

  // Monitor + scoreboard, sampled on the falling edge.
  initial forever begin
    beat_t e;
    int    my;
    bit    ms;
    @(negedge clk);
    if (rst) begin
      ready_run = 0;
      prev_hold = 0;
    end else begin
      ready_run = bus.out_ready ? ready_run + 1 : 0;
      check("in_ready_rule", bus.in_ready, longint'(!bus.out_valid || bus.out_ready));
      if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_y", bus.y, prev_y);
        check("hold_sat", bus.sat, prev_sat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          model(e, my, ms);
          check("y", bus.y, my);
          check("sat", bus.sat, ms);
          if (e.has_lit) begin
            check("lit_model_y", my, e.lit_y);
            check("lit_model_sat", ms, e.lit_sat);
            check("lit_dut_y", bus.y, e.lit_y);
            check("lit_dut_sat", bus.sat, e.lit_sat);
          end
          if (ready_run >= 4) check("latency", cyc - e.acc_cyc, 3);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = cur;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_y    = int'(bus.y);
      prev_sat  = int'(bus.sat);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk); rst = 1'b0;

    // Scaling, saturation, rounding and zero-point cases.
    push(40,    16384, 14, 0,   1, 40,   0);
    push(-10,   16384, 14, 0,   1, -10,  0);
    push(1000,  16384, 14, 0,   1, 127,  1);
    push(-1000, 16384, 14, 0,   1, -128, 1);
    push(3,     1,     1,  0,   1, 2,    0);
    push(-3,    1,     1,  0,   1, -1,   0);
    push(5,     1,     1,  0,   1, 3,    0);
    push(7,     1,     0,  0,   1, 7,    0);
    push(40,    16384, 14, -20, 1, 20,   0);
    push(40,    16384, 14, 100, 1, 127,  1);
    drain(100, 0);

    // Stream 0..7 with a consumer stall in the middle.
    @(posedge clk); #2;
    for (int i = 0; i < 8; i++) push(i, 1, 0, 0, 1, i, 0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      bus.out_ready = !(i >= 4 && i <= 8);
      if (i == 6) check("stall_in_ready", bus.in_ready, 0);
    end
    drain(40, 0);

    // Reset with beats in flight; the next output must be a fresh beat.
    for (int i = 0; i < 5; i++) push(50 + i, 1, 0, 0, 1, 50 + i, 0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk); #2;
      if (bus.out_valid) seen = 1;
    end
    check("pre_rst_out_valid", seen, 1);
    #1;
    stim_q.delete();
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_y", bus.y, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(77, 1, 0, 0, 1, 77, 0);
    drain(40, 0);

    // Randomized beats with random backpressure.
    for (int i = 0; i < 300; i++) push_rand();
    drain(5000, 1);

    repeat (4) @(posedge clk);
    check("leftover_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
